// File: rtl/sdram_arb.sv
// Two-master (CPU, DMA) arbiter in front of a single 32-bit SDRAM controller port.
// Define SDRAM_ARB_RR_EN for round-robin contention; otherwise DMA has fixed priority.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no owner; a pending request registers a grant
// S_CPU_CMD | CPU owns mem_*; waits for read/write acceptance
// S_DMA_CMD | DMA owns mem_*; waits for read/write acceptance
// S_CPU_RD  | counting CPU read beats down to zero
// S_DMA_RD  | waiting for the single DMA read beat
module sdram_arb #(
  parameter int BURST_W = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [19:0]        cpu_address,
  input  logic [31:0]        cpu_writedata,
  input  logic [3:0]         cpu_byteenable,
  input  logic [BURST_W-1:0] cpu_burstcount,
  input  logic               cpu_read,
  input  logic               cpu_write,
  output logic               cpu_waitrequest,
  output logic               cpu_readdatavalid,
  output logic [31:0]        cpu_readdata,
  input  logic [19:0]        dma_address,
  input  logic               dma_16bit,
  input  logic               dma_read,
  input  logic               dma_write,
  input  logic [15:0]        dma_writedata,
  output logic [15:0]        dma_readdata,
  output logic               dma_waitrequest,
  output logic               dma_readdatavalid,
  output logic [19:0]        mem_address,
  output logic [31:0]        mem_writedata,
  output logic [3:0]         mem_byteenable,
  output logic [BURST_W-1:0] mem_burstcount,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               mem_busy,
  input  logic               mem_dout_ready,
  input  logic [31:0]        mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_CMD,
    S_DMA_CMD,
    S_CPU_RD,
    S_DMA_RD
  } state_t;

  state_t             state, state_nxt;
  logic [BURST_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [1:0]         dma_lane;
  logic               dma_half;
  logic               cpu_req, dma_req, grant_dma;
  logic [19:0]        dma_addr_m;
  logic [31:0]        dma_wd_m;
  logic [3:0]         dma_be_m;

  assign cpu_req = cpu_read | cpu_write;
  assign dma_req = dma_read | dma_write;

`ifdef SDRAM_ARB_RR_EN
  logic last_cpu, last_cpu_nxt;
  assign grant_dma = dma_req & (~cpu_req | last_cpu);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) last_cpu <= 1'b1;
    else          last_cpu <= last_cpu_nxt;
  end
`else
  assign grant_dma = dma_req;
`endif

  // DMA lane steering happens on the fly while DMA owns the command bus
  always_comb begin
    if (dma_16bit) begin
      dma_addr_m = {dma_address[19:1], 1'b0};
      dma_be_m   = dma_address[1] ? 4'b1100 : 4'b0011;
      dma_wd_m   = {2{dma_writedata}};
    end else begin
      dma_addr_m = dma_address;
      dma_be_m   = 4'b0001 << dma_address[1:0];
      dma_wd_m   = {4{dma_writedata[7:0]}};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      dma_lane <= 2'b00;
      dma_half <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      // lane held past acceptance so the read return can be steered
      if (state == S_DMA_CMD) begin
        dma_lane <= dma_address[1:0];
        dma_half <= dma_16bit;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    beat_cnt_nxt      = beat_cnt;
    mem_address       = '0;
    mem_writedata     = '0;
    mem_byteenable    = '0;
    mem_burstcount    = '0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    cpu_waitrequest   = 1'b1;
    dma_waitrequest   = 1'b1;
    cpu_readdatavalid = 1'b0;
    dma_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_cpu_nxt      = last_cpu;
`endif
    case (state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          state_nxt = grant_dma ? S_DMA_CMD : S_CPU_CMD;
`ifdef SDRAM_ARB_RR_EN
          last_cpu_nxt = ~grant_dma;
`endif
        end
      end
      S_CPU_CMD: begin
        mem_address     = {cpu_address[19:2], 2'b00};
        mem_writedata   = cpu_writedata;
        mem_byteenable  = cpu_byteenable;
        mem_burstcount  = cpu_burstcount;
        mem_write       = cpu_write;
        mem_read        = cpu_read & ~cpu_write;
        cpu_waitrequest = mem_busy;
        if (!cpu_req) begin
          state_nxt = S_IDLE;
        end else if (!mem_busy) begin
          if (cpu_write) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt    = S_CPU_RD;
            beat_cnt_nxt = (cpu_burstcount == '0) ? BURST_W'(1) : cpu_burstcount;
          end
        end
      end
      S_DMA_CMD: begin
        mem_address     = dma_addr_m;
        mem_writedata   = dma_wd_m;
        mem_byteenable  = dma_be_m;
        mem_burstcount  = BURST_W'(1);
        mem_write       = dma_write;
        mem_read        = dma_read & ~dma_write;
        dma_waitrequest = mem_busy;
        if (!dma_req) begin
          state_nxt = S_IDLE;
        end else if (!mem_busy) begin
          if (dma_write) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt    = S_DMA_RD;
            beat_cnt_nxt = BURST_W'(1);
          end
        end
      end
      S_CPU_RD, S_DMA_RD: begin
        cpu_readdatavalid = mem_dout_ready & (state == S_CPU_RD);
        dma_readdatavalid = mem_dout_ready & (state == S_DMA_RD);
        if (mem_dout_ready) begin
          beat_cnt_nxt = beat_cnt - BURST_W'(1);
          if (beat_cnt <= BURST_W'(1)) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_readdata = mem_dout;
    if (dma_half) begin
      dma_readdata = dma_lane[1] ? mem_dout[31:16] : mem_dout[15:0];
    end else begin
      case (dma_lane)
        2'd0:    dma_readdata = {8'h00, mem_dout[7:0]};
        2'd1:    dma_readdata = {8'h00, mem_dout[15:8]};
        2'd2:    dma_readdata = {8'h00, mem_dout[23:16]};
        default: dma_readdata = {8'h00, mem_dout[31:24]};
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Randomized bench for sdram_arb against a transaction-level model of the arbiter.
// Honours SDRAM_ARB_RR_EN when choosing the expected winner of contended grants.
module tb_sdram_arb;
  localparam int BW = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [19:0]   cpu_address;
  logic [31:0]   cpu_writedata;
  logic [3:0]    cpu_byteenable;
  logic [BW-1:0] cpu_burstcount;
  logic          cpu_read, cpu_write;
  logic          cpu_waitrequest, cpu_readdatavalid;
  logic [31:0]   cpu_readdata;
  logic [19:0]   dma_address;
  logic          dma_16bit, dma_read, dma_write;
  logic [15:0]   dma_writedata, dma_readdata;
  logic          dma_waitrequest, dma_readdatavalid;
  logic [19:0]   mem_address;
  logic [31:0]   mem_writedata;
  logic [3:0]    mem_byteenable;
  logic [BW-1:0] mem_burstcount;
  logic          mem_read, mem_write;
  logic          mem_busy, mem_dout_ready;
  logic [31:0]   mem_dout;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  last_cpu_served;
  bit  force_dout_en = 0;
  logic [31:0] force_dout;

  sdram_arb #(.BURST_W(BW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_byteenable(cpu_byteenable), .cpu_burstcount(cpu_burstcount),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdatavalid(cpu_readdatavalid),
    .cpu_readdata(cpu_readdata),
    .dma_address(dma_address), .dma_16bit(dma_16bit),
    .dma_read(dma_read), .dma_write(dma_write),
    .dma_writedata(dma_writedata), .dma_readdata(dma_readdata),
    .dma_waitrequest(dma_waitrequest), .dma_readdatavalid(dma_readdatavalid),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_burstcount(mem_burstcount),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_busy(mem_busy), .mem_dout_ready(mem_dout_ready), .mem_dout(mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  // reference mapping rules, plain arithmetic on the request fields
  function automatic logic [19:0] dma_addr_f(logic [19:0] a, logic h);
    return h ? a - (a % 20'd2) : a;
  endfunction
  function automatic logic [3:0] dma_be_f(logic [19:0] a, logic h);
    if (h) return ((a % 20'd4) >= 20'd2) ? 4'd12 : 4'd3;
    return 4'(32'd1 << 32'(a % 20'd4));
  endfunction
  function automatic logic [31:0] dma_wd_f(logic [15:0] wd, logic h);
    if (h) return 32'(wd) * 32'h0001_0001;
    return 32'(wd % 16'd256) * 32'h0101_0101;
  endfunction
  function automatic logic [15:0] dma_rd_f(logic [31:0] d, logic [19:0] a, logic h);
    if (h) return 16'(d >> (32'd16 * 32'((a / 20'd2) % 20'd2)));
    return 16'(8'(d >> (32'd8 * 32'(a % 20'd4))));
  endfunction

  function automatic bit pick_dma();
    bit cp = cpu_read | cpu_write;
    bit dp = dma_read | dma_write;
    if (!cp) return 1'b1;
    if (!dp) return 1'b0;
`ifdef SDRAM_ARB_RR_EN
    return last_cpu_served;
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_owner(input bit own_dma);
    if (own_dma) begin dma_read = 0; dma_write = 0; end
    else begin cpu_read = 0; cpu_write = 0; end
  endtask

  task automatic do_reset();
    reset_n = 0;
    cpu_read = 0; cpu_write = 0; dma_read = 0; dma_write = 0;
    mem_busy = 0; mem_dout_ready = 0;
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    chk("rst_mem_cmd", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_waitreq", 32'({cpu_waitrequest, dma_waitrequest}), 32'd3);
    chk("rst_valid", 32'({cpu_readdatavalid, dma_readdatavalid}), 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1;
    last_cpu_served = 1;
  endtask

  // Entered at posedge+1 with the arbiter idle and the owner's request driven.
  task automatic serve_one(input bit own_dma, input int busy, input bit drop, input int abort_after);
    logic [19:0]   e_addr;
    logic [31:0]   e_wd;
    logic [3:0]    e_be;
    logic [BW-1:0] e_bc;
    bit            e_wr, e_rd;
    int            beats, gap;
    logic [31:0]   d;
    logic [19:0]   la;
    logic          lh;
    if (own_dma) begin
      e_addr = dma_addr_f(dma_address, dma_16bit);
      e_wd = dma_wd_f(dma_writedata, dma_16bit);
      e_be = dma_be_f(dma_address, dma_16bit);
      e_bc = BW'(1);
      e_wr = dma_write; e_rd = dma_read && !dma_write;
      beats = 1;
    end else begin
      e_addr = cpu_address - (cpu_address % 20'd4);
      e_wd = cpu_writedata; e_be = cpu_byteenable; e_bc = cpu_burstcount;
      e_wr = cpu_write; e_rd = cpu_read && !cpu_write;
      beats = (cpu_burstcount == 0) ? 1 : int'(cpu_burstcount);
    end
    la = dma_address; lh = dma_16bit;
    @(negedge clk_sys);
    chk("idle_mem_cmd", 32'({mem_read, mem_write}), 32'd0);
    chk("idle_waitreq", 32'({cpu_waitrequest, dma_waitrequest}), 32'd3);
    @(posedge clk_sys); #1;
    last_cpu_served = !own_dma;
    if (drop) begin
      clear_owner(own_dma);
      @(negedge clk_sys);
      chk("drop_mem_cmd", 32'({mem_read, mem_write}), 32'd0);
      @(posedge clk_sys); #1;
      return;
    end
    for (int i = 0; i <= busy; i++) begin
      mem_busy = (i < busy);
      @(negedge clk_sys);
      chk("cmd_addr", 32'(mem_address), 32'(e_addr));
      chk("cmd_wdata", mem_writedata, e_wd);
      chk("cmd_be", 32'(mem_byteenable), 32'(e_be));
      chk("cmd_bc", 32'(mem_burstcount), 32'(e_bc));
      chk("cmd_rw", 32'({mem_read, mem_write}), 32'({e_rd, e_wr}));
      chk("own_waitreq", 32'(own_dma ? dma_waitrequest : cpu_waitrequest), 32'(i < busy));
      chk("other_waitreq", 32'(own_dma ? cpu_waitrequest : dma_waitrequest), 32'd1);
      @(posedge clk_sys); #1;
    end
    mem_busy = 0;
    clear_owner(own_dma);
    if (e_wr) return;
    for (int b = 1; b <= beats; b++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_dout = $urandom;
        @(negedge clk_sys);
        chk("gap_valid", 32'({cpu_readdatavalid, dma_readdatavalid}), 32'd0);
        chk("rd_waitreq", 32'({cpu_waitrequest, dma_waitrequest}), 32'd3);
        @(posedge clk_sys); #1;
      end
      d = force_dout_en ? force_dout : $urandom;
      mem_dout = d; mem_dout_ready = 1;
      @(negedge clk_sys);
      chk("beat_valid", 32'({cpu_readdatavalid, dma_readdatavalid}), own_dma ? 32'd1 : 32'd2);
      if (own_dma) chk("dma_rdata", 32'(dma_readdata), 32'(dma_rd_f(d, la, lh)));
      else         chk("cpu_rdata", cpu_readdata, d);
      @(posedge clk_sys); #1;
      mem_dout_ready = 0;
      if (b == abort_after) return;
    end
  endtask

  task automatic stray_pulse(input string tag);
    mem_dout_ready = 1; mem_dout = $urandom;
    @(negedge clk_sys);
    chk(tag, 32'({cpu_readdatavalid, dma_readdatavalid}), 32'd0);
    @(posedge clk_sys); #1;
    mem_dout_ready = 0;
  endtask

  task automatic new_cpu();
    int k = $urandom_range(0, 7);
    cpu_write = (k < 3) || (k == 7);
    cpu_read = (k >= 3);
    cpu_address = 20'($urandom);
    cpu_writedata = $urandom;
    cpu_byteenable = 4'($urandom);
    cpu_burstcount = BW'($urandom);
  endtask

  task automatic new_dma();
    bit w = 1'($urandom);
    dma_write = w; dma_read = !w;
    dma_address = 20'($urandom);
    dma_16bit = 1'($urandom);
    dma_writedata = 16'($urandom);
  endtask

  initial begin
    bit w1, w2, own;
    reset_n = 0; cpu_read = 0; cpu_write = 0; dma_read = 0; dma_write = 0;
    cpu_address = 0; cpu_writedata = 0; cpu_byteenable = 0; cpu_burstcount = 0;
    dma_address = 0; dma_16bit = 0; dma_writedata = 0;
    mem_busy = 0; mem_dout_ready = 0; mem_dout = 0; force_dout = 0;
    repeat (2) @(posedge clk_sys);
    #1;
    do_reset();

    // CPU 4-beat read, then a stray beat while idle
    cpu_address = 20'h01234; cpu_burstcount = 4; cpu_byteenable = 4'hF; cpu_read = 1;
    serve_one(pick_dma(), 0, 0, 0);
    stray_pulse("stray_after_cpu_rd");

    // DMA byte write at lane 3
    dma_address = 20'h00403; dma_16bit = 0; dma_writedata = 16'h005A; dma_write = 1;
    serve_one(pick_dma(), 0, 0, 0);

    // DMA halfword read from the upper half
    dma_address = 20'h00406; dma_16bit = 1; dma_read = 1;
    force_dout_en = 1; force_dout = 32'hBEEF_1234;
    serve_one(pick_dma(), 0, 0, 0);
    force_dout_en = 0;

    // CPU write stalled five cycles
    cpu_address = 20'h0ABCD; cpu_writedata = 32'hCAFE_F00D; cpu_byteenable = 4'h6; cpu_write = 1;
    serve_one(pick_dma(), 5, 0, 0);

    // contention twice in a row from a fresh pointer
    do_reset();
    cpu_address = 20'h00100; cpu_burstcount = 2; cpu_read = 1;
    dma_address = 20'h00200; dma_16bit = 0; dma_read = 1;
    w1 = pick_dma();
    chk("contend1_model_dma", 32'(w1), 32'd1);
    serve_one(w1, 0, 0, 0);
    if (w1) begin dma_address = 20'h00301; dma_read = 1; end
    else begin cpu_address = 20'h00104; cpu_read = 1; end
    w2 = pick_dma();
    serve_one(w2, 1, 0, 0);
    while (cpu_read || cpu_write || dma_read || dma_write) serve_one(pick_dma(), 0, 0, 0);

    // owner withdraws, then re-issues immediately
    dma_address = 20'h00010; dma_write = 1;
    serve_one(pick_dma(), 0, 1, 0);
    dma_write = 1;
    serve_one(pick_dma(), 0, 0, 0);

    // reset in the middle of a 4-beat CPU read
    cpu_address = 20'h02000; cpu_burstcount = 4; cpu_read = 1;
    serve_one(pick_dma(), 0, 0, 2);
    do_reset();
    stray_pulse("stray_after_reset1");
    stray_pulse("stray_after_reset2");

    for (int it = 0; it < 120; it++) begin
      if (!(cpu_read || cpu_write) && $urandom_range(0, 1) == 1) new_cpu();
      if (!(dma_read || dma_write) && $urandom_range(0, 1) == 1) new_dma();
      if (!(cpu_read || cpu_write || dma_read || dma_write)) new_dma();
      own = pick_dma();
      serve_one(own, $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
- REQ-001 Parameter: BURST_W, default 4, width of CPU/memory burstcount.
- REQ-002 clk_sys  in  1  single system clock; all logic on rising edge.
- REQ-003 reset_n  in  1  synchronous, active-low reset.
- REQ-004 cpu_address  in  20  CPU byte address; bits [1:0] ignored.
- REQ-005 cpu_writedata  in  32  CPU write data.
- REQ-006 cpu_byteenable  in  4  CPU byte lanes.
- REQ-007 cpu_burstcount  in  BURST_W  CPU read beats; 0 treated as 1.
- REQ-008 cpu_read / cpu_write  in  1 each  CPU Avalon commands, held until accepted.
- REQ-009 cpu_waitrequest  out  1  CPU stall.
- REQ-010 cpu_readdatavalid  out  1 / cpu_readdata  out  32  CPU read return.
- REQ-011 dma_address  in  20  DMA byte address.
- REQ-012 dma_16bit  in  1  1 = halfword transfer, 0 = byte.
- REQ-013 dma_read / dma_write  in  1 each  DMA commands, held until accepted.
- REQ-014 dma_writedata  in  16 / dma_readdata  out  16  DMA data.
- REQ-015 dma_waitrequest  out  1 / dma_readdatavalid  out  1  DMA handshake.
- REQ-016 mem_address  out  20 / mem_writedata  out  32 / mem_byteenable  out  4 / mem_burstcount  out  BURST_W / mem_read, mem_write  out  1  memory command.
- REQ-017 mem_busy  in  1 / mem_dout_ready  in  1 / mem_dout  in  32  memory stall and read return.

Function
- REQ-018 States IDLE, CPU_CMD, DMA_CMD, CPU_RD, DMA_RD; one owner at a time.
- REQ-019 IDLE: a pending request registers a grant; next cycle enters CPU_CMD or DMA_CMD (one cycle grant latency); no memory command driven in IDLE.
- REQ-020 In xxx_CMD, mem_* reflect the owner's command combinationally; owner waitrequest = mem_busy; non-owner waitrequest = 1.
- REQ-021 Command accepted on a cycle with mem_read|mem_write high and mem_busy low.
- REQ-022 Accepted write -> IDLE next cycle; accepted read -> CPU_RD/DMA_RD.
- REQ-023 Owner drops both commands in xxx_CMD -> IDLE, no memory command issued.
- REQ-024 xxx_RD: beat counter loaded with burst length (CPU: burstcount, 0->1; DMA: 1); each mem_dout_ready decrements; last beat -> IDLE next cycle; both waitrequests = 1.
- REQ-025 mem_dout_ready routed only to the owner's readdatavalid, same cycle, no registering; mem_dout_ready outside xxx_RD ignored.
- REQ-026 CPU path: address {cpu_address[19:2],2'b00}, data/byteenable/burstcount passed unchanged.
- REQ-027 DMA byte: byteenable = 1<<a[1:0], writedata = {4{wd[7:0]}}, burstcount = 1, readdata = {8'h00, selected byte}.
- REQ-028 DMA halfword: a[0] forced 0, byteenable = 4'b0011 or 4'b1100 by a[1], writedata = {2{wd}}, readdata = selected halfword.
- REQ-029 Simultaneous CPU and DMA requests in IDLE resolved by arbitration policy (REQ-033).
- REQ-030 Simultaneous read and write from the same requester: write takes precedence.

Reset
- REQ-031 reset_n low at a clock edge: state IDLE, beat counter 0, round-robin pointer to CPU-last-served, mem_read=mem_write=0, both readdatavalid=0, both waitrequest=1.
- REQ-032 Reset mid-burst abandons outstanding beats; subsequent stray mem_dout_ready ignored until a new read is accepted.

Configuration
- REQ-033 Macro SDRAM_ARB_RR_EN: defined -> round-robin, contended grant goes to the requester not served last; undefined -> fixed priority, DMA always wins contention and the pointer is absent.

Verification
- REQ-034 CPU read 0x01234, burstcount 4, mem_busy 0 -> mem_address 0x01234 masked to 0x01234&~3=0x01234, 4 beats to cpu_readdatavalid, IDLE after beat 4.
- REQ-035 DMA byte write addr 0x00403, data 0x5A -> mem_byteenable 4'b1000, mem_writedata 0x5A5A5A5A, dma_waitrequest low on accept cycle only.
- REQ-036 DMA halfword read addr 0x00406, mem_dout 0xBEEF1234 -> dma_readdata 0xBEEF, one dma_readdatavalid pulse.
- REQ-037 CPU and DMA both read in IDLE, twice in a row -> without macro DMA granted both times; with SDRAM_ARB_RR_EN DMA then CPU.
- REQ-038 mem_busy held high 5 cycles in CPU_CMD -> command stable, cpu_waitrequest high 5 cycles, dma_waitrequest high throughout.
- REQ-039 reset_n low after beat 2 of 4-beat CPU read -> IDLE, later 2 mem_dout_ready pulses produce no readdatavalid.
